// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass and stall-time operand refresh
module id_ex_stage #(
   parameter int N      = 32,
   parameter int CTRL_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [N-1:0]      id_pc,
   input  logic [N-1:0]      id_imm,
   input  logic [4:0]        id_rs1_addr,
   input  logic [4:0]        id_rs2_addr,
   input  logic [4:0]        id_rd_addr,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [N-1:0]      rf_rs1,
   input  logic [N-1:0]      rf_rs2,
   input  logic              wb_regwrite,
   input  logic [4:0]        wb_rd_addr,
   input  logic [N-1:0]      wb_data,
   output logic              ex_valid,
   output logic [N-1:0]      ex_pc,
   output logic [N-1:0]      ex_imm,
   output logic [N-1:0]      ex_rs1,
   output logic [N-1:0]      ex_rs2,
   output logic [4:0]        ex_rs1_addr,
   output logic [4:0]        ex_rs2_addr,
   output logic [4:0]        ex_rd_addr,
   output logic [CTRL_W-1:0] ex_ctrl
);

   logic              valid_q,    valid_d;
   logic [N-1:0]      pc_q,       pc_d;
   logic [N-1:0]      imm_q,      imm_d;
   logic [N-1:0]      rs1_q,      rs1_d;
   logic [N-1:0]      rs2_q,      rs2_d;
   logic [4:0]        rs1_addr_q, rs1_addr_d;
   logic [4:0]        rs2_addr_q, rs2_addr_d;
   logic [4:0]        rd_addr_q,  rd_addr_d;
   logic [CTRL_W-1:0] ctrl_q,     ctrl_d;

   logic              wb_live;
   logic [N-1:0]      id_op1, id_op2;

   // Operand values as they should enter EX: x0 is hard zero, a same-cycle WB write wins over the stale RF read
   always_comb begin
      wb_live = wb_regwrite && (wb_rd_addr != 5'd0);
      if (id_rs1_addr == 5'd0)
         id_op1 = '0;
      else if (wb_live && (wb_rd_addr == id_rs1_addr))
         id_op1 = wb_data;
      else
         id_op1 = rf_rs1;
      if (id_rs2_addr == 5'd0)
         id_op2 = '0;
      else if (wb_live && (wb_rd_addr == id_rs2_addr))
         id_op2 = wb_data;
      else
         id_op2 = rf_rs2;
   end

   // Next-state selection: flush bubble beats stall hold, which beats a normal load
   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_addr_d  = rd_addr_q;
      ctrl_d     = ctrl_q;
      if (flush) begin
         valid_d    = 1'b0;
         pc_d       = '0;
         imm_d      = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         rs1_addr_d = '0;
         rs2_addr_d = '0;
         rd_addr_d  = '0;
         ctrl_d     = '0;
      end else if (!stall) begin
         valid_d    = id_valid;
         pc_d       = id_pc;
         imm_d      = id_imm;
         rs1_d      = id_op1;
         rs2_d      = id_op2;
         rs1_addr_d = id_rs1_addr;
         rs2_addr_d = id_rs2_addr;
         rd_addr_d  = id_rd_addr;
         // A non-valid entry must never carry RegWrite (or any other control) into EX
         ctrl_d     = id_valid ? id_ctrl : '0;
      end else if (valid_q && wb_live) begin
         // Producer retiring while we sit stalled: refresh the held operand so it is not stale
         if (wb_rd_addr == rs1_addr_q) rs1_d = wb_data;
         if (wb_rd_addr == rs2_addr_q) rs2_d = wb_data;
      end
   end

   // Pipeline register state with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         ctrl_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_pc       = pc_q;
   assign ex_imm      = imm_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_rs1_addr = rs1_addr_q;
   assign ex_rs2_addr = rs2_addr_q;
   assign ex_rd_addr  = rd_addr_q;
   assign ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
   localparam int N      = 32;
   localparam int CTRL_W = 12;
   localparam int OBS_W  = 1 + 4*N + 15 + CTRL_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall, flush, id_valid;
   logic [N-1:0]      id_pc, id_imm;
   logic [4:0]        id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [CTRL_W-1:0] id_ctrl;
   logic [N-1:0]      rf_rs1, rf_rs2;
   logic              wb_regwrite;
   logic [4:0]        wb_rd_addr;
   logic [N-1:0]      wb_data;
   logic              ex_valid;
   logic [N-1:0]      ex_pc, ex_imm, ex_rs1, ex_rs2;
   logic [4:0]        ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
   logic [CTRL_W-1:0] ex_ctrl;

   id_ex_stage #(.N(N), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_ctrl(id_ctrl), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
      .ex_ctrl(ex_ctrl)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model of what EX should hold
   typedef struct {
      logic              valid;
      logic [N-1:0]      pc, imm, rs1, rs2;
      logic [4:0]        a1, a2, rd;
      logic [CTRL_W-1:0] ctrl;
   } ex_t;
   ex_t m;

   function automatic logic [OBS_W-1:0] obs();
      return {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl};
   endfunction

   function automatic logic [OBS_W-1:0] expv();
      return {m.valid, m.pc, m.imm, m.rs1, m.rs2, m.a1, m.a2, m.rd, m.ctrl};
   endfunction

   // Value the register file would "really" contain for reg a this cycle
   function automatic logic [N-1:0] operand(input logic [4:0] a, input logic [N-1:0] rf);
      if (a == 0) return '0;
      if (wb_regwrite && wb_rd_addr == a) return wb_data;
      return rf;
   endfunction

   function automatic void model_clear();
      m = '{valid: 1'b0, pc: '0, imm: '0, rs1: '0, rs2: '0, a1: '0, a2: '0, rd: '0, ctrl: '0};
   endfunction

   function automatic void model_edge();
      if (rst) begin
         model_clear();
      end else if (flush) begin
         model_clear();
      end else if (stall) begin
         if (m.valid && wb_regwrite && wb_rd_addr != 0) begin
            if (wb_rd_addr == m.a1) m.rs1 = wb_data;
            if (wb_rd_addr == m.a2) m.rs2 = wb_data;
         end
      end else begin
         m.valid = id_valid;
         m.pc    = id_pc;
         m.imm   = id_imm;
         m.rs1   = operand(id_rs1_addr, rf_rs1);
         m.rs2   = operand(id_rs2_addr, rf_rs2);
         m.a1    = id_rs1_addr;
         m.a2    = id_rs2_addr;
         m.rd    = id_rd_addr;
         m.ctrl  = id_valid ? id_ctrl : '0;
      end
   endfunction

   task automatic rand_inputs();
      id_valid    = ($urandom_range(0, 3) != 0);
      id_pc       = $urandom;
      id_imm      = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr  = 5'($urandom);
      id_ctrl     = CTRL_W'($urandom);
      rf_rs1      = $urandom;
      rf_rs2      = $urandom;
      wb_regwrite = $urandom_range(0, 1);
      wb_rd_addr  = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
   endtask

   // Inputs are set at the falling edge; advance one rising edge and sample 1 time unit later
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic go_negedge();
      @(negedge clk);
      stall = 0; flush = 0;
      rand_inputs();
   endtask

   task automatic test_reset();
      total_cnt++;
      if (obs() !== '0) $display("FAIL reset_init: got %h want 0", obs());
      else pass_cnt++;
      @(negedge clk);
      rst = 0;
      model_clear();
   endtask

   task automatic test_plain_load();
      logic [CTRL_W-1:0] c;
      go_negedge();
      id_valid = 1; id_rs1_addr = 5; rf_rs1 = 32'h11; wb_regwrite = 0;
      c = id_ctrl;
      cycle();
      total_cnt++;
      if (ex_rs1 !== 32'h11 || ex_valid !== 1'b1 || ex_ctrl !== c)
         $display("FAIL plain_load: rs1=%h valid=%b ctrl=%h want 11 1 %h", ex_rs1, ex_valid, ex_ctrl, c);
      else pass_cnt++;
      total_cnt++;
      if (obs() !== expv()) $display("FAIL plain_load_all: got %h want %h", obs(), expv());
      else pass_cnt++;
      // Non-valid entry loads with control forced to zero
      go_negedge();
      id_valid = 0; id_ctrl = '1;
      cycle();
      total_cnt++;
      if (ex_ctrl !== '0 || ex_valid !== 1'b0) $display("FAIL invalid_ctrl: ctrl=%h valid=%b want 0 0", ex_ctrl, ex_valid);
      else pass_cnt++;
   endtask

   task automatic test_wb_bypass();
      go_negedge();
      id_rs2_addr = 7; rf_rs2 = 32'hAAAA; wb_regwrite = 1; wb_rd_addr = 7; wb_data = 32'h1234;
      cycle();
      total_cnt++;
      if (ex_rs2 !== 32'h1234) $display("FAIL wb_bypass: ex_rs2=%h want 1234", ex_rs2);
      else pass_cnt++;
      go_negedge();
      id_rs2_addr = 7; rf_rs2 = 32'hAAAA; wb_regwrite = 1; wb_rd_addr = 0; wb_data = 32'h1234;
      cycle();
      total_cnt++;
      if (ex_rs2 !== 32'hAAAA) $display("FAIL wb_x0_nobypass: ex_rs2=%h want aaaa", ex_rs2);
      else pass_cnt++;
      // Both sources name the WB target: both pick up WB data
      go_negedge();
      id_rs1_addr = 6; id_rs2_addr = 6; wb_regwrite = 1; wb_rd_addr = 6; wb_data = 32'hC0DE;
      cycle();
      total_cnt++;
      if (ex_rs1 !== 32'hC0DE || ex_rs2 !== 32'hC0DE) $display("FAIL same_src: rs1=%h rs2=%h want c0de", ex_rs1, ex_rs2);
      else pass_cnt++;
   endtask

   task automatic test_stall_refresh();
      logic [N-1:0]      hpc, himm, hrs2;
      logic [CTRL_W-1:0] hctrl;
      logic [4:0]        hrd;
      go_negedge();
      id_valid = 1; id_rs1_addr = 3; id_rs2_addr = 4; rf_rs1 = 32'h1111; wb_regwrite = 0;
      cycle();
      hpc = id_pc; himm = id_imm; hrs2 = rf_rs2; hctrl = id_ctrl; hrd = id_rd_addr;
      for (int k = 1; k <= 3; k++) begin
         go_negedge();
         stall = 1;
         wb_regwrite = (k == 2);
         wb_rd_addr  = (k == 2) ? 5'd3 : 5'd9;
         wb_data     = 32'hBEEF;
         cycle();
         total_cnt++;
         if (ex_rs1 !== ((k >= 2) ? 32'hBEEF : 32'h1111))
            $display("FAIL stall_refresh_c%0d: ex_rs1=%h want %h", k, ex_rs1, (k >= 2) ? 32'hBEEF : 32'h1111);
         else pass_cnt++;
         total_cnt++;
         if (ex_pc !== hpc || ex_imm !== himm || ex_rs2 !== hrs2 || ex_ctrl !== hctrl || ex_rd_addr !== hrd
             || ex_valid !== 1'b1 || ex_rs1_addr !== 5'd3)
            $display("FAIL stall_hold_c%0d: got %h", k, obs());
         else pass_cnt++;
      end
   endtask

   task automatic test_flush_priority();
      go_negedge();
      stall = 1; flush = 1; id_valid = 1; id_ctrl = '1;
      cycle();
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd_addr !== 5'd0)
         $display("FAIL flush_prio: valid=%b ctrl=%h rd=%h want 0 0 0", ex_valid, ex_ctrl, ex_rd_addr);
      else pass_cnt++;
      total_cnt++;
      if (obs() !== '0) $display("FAIL flush_zero: got %h want 0", obs());
      else pass_cnt++;
   endtask

   task automatic test_x0_source();
      go_negedge();
      id_valid = 1; id_rs1_addr = 0; rf_rs1 = 32'hFFFF; wb_regwrite = 1; wb_rd_addr = 0; wb_data = 5;
      cycle();
      total_cnt++;
      if (ex_rs1 !== '0) $display("FAIL x0_source: ex_rs1=%h want 0", ex_rs1);
      else pass_cnt++;
   endtask

   task automatic test_reset_midrun();
      go_negedge();
      id_valid = 1;
      cycle();
      total_cnt++;
      if (ex_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", ex_valid);
      else pass_cnt++;
      @(negedge clk);
      #2 rst = 1;
      #1;
      model_clear();
      total_cnt++;
      if (obs() !== '0) $display("FAIL async_reset: got %h want 0", obs());
      else pass_cnt++;
      @(negedge clk);
      rst = 0;
      stall = 0; flush = 0;
      rand_inputs();
      cycle();
      total_cnt++;
      if (obs() !== expv()) $display("FAIL post_reset_load: got %h want %h", obs(), expv());
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rand_inputs();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         cycle();
         total_cnt++;
         if (obs() !== expv()) $display("FAIL random_%0d: got %h want %h", i, obs(), expv());
         else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0;
      rand_inputs();
      #12;
      test_reset();
      test_plain_load();
      test_wb_bypass();
      test_stall_refresh();
      test_flush_priority();
      test_x0_source();
      test_reset_midrun();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
